// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad row scanner.
// No logic beyond a pure helper function.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam logic [3:0] COL_IDLE  = 4'b1111;
    localparam logic [3:0] ROW_IDLE  = 4'b1111;
    localparam logic [3:0] ROW_FIRST = 4'b1110;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_SCAN    = 2'd1,
        ST_LOCK    = 2'd2,
        ST_ADVANCE = 2'd3
    } scan_state_t;

    // True when exactly one row line is pulled low.
    function automatic logic row_onehot_low(input logic [NUM_ROWS-1:0] r);
        logic [NUM_ROWS-1:0] a;
        a = ~r;
        return (a != '0) && ((a & (a - NUM_ROWS'(1))) == '0);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle).
// Latency 2 cycles; no backpressure.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/keypad_scan_sched.sv
// Keypad row scanner: drives rows in turn, settles, dwells, and locks on a pressed key.
// Columns reach col_out 2 cycles after col_raw; hold from the key controller freezes the scan.
module keypad_scan_sched
    import keypad_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int DWELL  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] col_raw,
    input  logic       hold,
    output logic [3:0] row_drive,
    output logic [3:0] col_out,
    output logic [3:0] row_out,
    output logic [1:0] scan_idx,
    output logic [1:0] debug_state
);

    localparam int IDX_W = $clog2(NUM_ROWS);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] DWELL_LAST  = 8'(DWELL - 1);

    scan_state_t        state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         row_q, row_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         col_sync;

    sync2 #(.WIDTH(4)) u_col_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (col_raw),
        .q    (col_sync)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
            row_q   <= ROW_FIRST;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        idx_d   = idx_q;
        if (!row_onehot_low(row_q)) begin
            // Corrupted row drive: restart the scan from row 0.
            state_d = ST_SETTLE;
            cnt_d   = '0;
            row_d   = ROW_FIRST;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SCAN: begin
                    // A key wins over both dwell expiry and hold.
                    if (col_sync != COL_IDLE) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else if (!hold) begin
                        if (cnt_q == DWELL_LAST) begin
                            state_d = ST_ADVANCE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (!hold && (col_sync == COL_IDLE)) begin
                        state_d = ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    row_d   = {row_q[2:0], row_q[3]};
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                default: begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        col_out = COL_IDLE;
        row_out = ROW_IDLE;
        if ((state_q == ST_SCAN) || (state_q == ST_LOCK)) begin
            col_out = col_sync;
            row_out = row_q;
        end
    end

    assign row_drive   = row_q;
    assign scan_idx    = idx_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_keypad_scan_sched.sv
// Bench for keypad_scan_sched: a timeline model predicts every state change,
// a monitor checks each DUT state change against the predicted queue.
module tb_keypad_scan_sched;

    localparam int SET = 4;
    localparam int DW  = 16;
    localparam int P_SETTLE = 0, P_SCAN = 1, P_LOCK = 2, P_ADV = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] col_raw = 4'b1111;
    logic [3:0] row_drive, col_out, row_out;
    logic [1:0] scan_idx, debug_state;

    always #5 clk = ~clk;

    keypad_scan_sched #(.SETTLE(SET), .DWELL(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .col_raw     (col_raw),
        .hold        (hold),
        .row_drive   (row_drive),
        .col_out     (col_out),
        .row_out     (row_out),
        .scan_idx    (scan_idx),
        .debug_state (debug_state)
    );

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [3:0] row;
        logic [1:0] idx;
        logic [3:0] col;
        logic [3:0] rout;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Reference model: phase, cycles left in the phase, row index, column pipeline.
    int         m_ph = P_SETTLE;
    int         m_left = SET;
    int         m_idx = 0;
    logic [3:0] m_s1 = 4'b1111;
    logic [3:0] m_s2 = 4'b1111;

    bit key_on = 0;
    int key_row = 0;
    int key_col = 0;
    bit mon_en = 0;
    bit cur_h = 0;

    function automatic logic [3:0] row_of(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    task automatic step(input bit r, input bit h);
        int  old_ph;
        ev_t e;
        rstn = r;
        hold = h;
        col_raw = (key_on && (m_idx == key_row)) ? row_of(key_col) : 4'b1111;
        @(posedge clk);
        cyc++;
        old_ph = m_ph;
        if (!r) begin
            m_ph = P_SETTLE; m_left = SET; m_idx = 0;
        end else begin
            case (m_ph)
                P_SETTLE: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = P_SCAN; m_left = DW; end
                end
                P_SCAN: begin
                    if (m_s2 != 4'b1111) m_ph = P_LOCK;
                    else if (!h) begin
                        m_left--;
                        if (m_left == 0) m_ph = P_ADV;
                    end
                end
                P_LOCK: if (!h && m_s2 == 4'b1111) m_ph = P_ADV;
                default: begin
                    m_idx = (m_idx + 1) % 4;
                    m_ph = P_SETTLE; m_left = SET;
                end
            endcase
        end
        if (!r) begin
            m_s1 = 4'b1111; m_s2 = 4'b1111;
        end else begin
            m_s2 = m_s1; m_s1 = col_raw;
        end
        if (m_ph != old_ph) begin
            e.cyc  = cyc;
            e.st   = 2'(m_ph);
            e.row  = row_of(m_idx);
            e.idx  = 2'(m_idx);
            e.col  = (m_ph == P_SCAN || m_ph == P_LOCK) ? m_s2 : 4'b1111;
            e.rout = (m_ph == P_SCAN || m_ph == P_LOCK) ? row_of(m_idx) : 4'b1111;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit h);
        for (int i = 0; i < n; i++) step(1'b1, h);
    endtask

    // Step until the model reaches phase ph (and left count, if left_req >= 0).
    task automatic wait_ph(input int ph, input int left_req, input bit h, input string name);
        int n;
        n = 0;
        while (!(m_ph == ph && (left_req < 0 || m_left == left_req)) && n < 400) begin
            step(1'b1, h);
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL %s: wait budget expired, phase %0d required %0d", name, m_ph, ph);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    logic [1:0] last_st = 2'd0;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (mon_en && (debug_state !== last_st)) begin
            last_st = debug_state;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_transition: state %0d row %b at cycle %0d, required no change",
                         debug_state, row_drive, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.st !== debug_state || mon_e.row !== row_drive ||
                    mon_e.idx !== scan_idx || mon_e.col !== col_out || mon_e.rout !== row_out) begin
                    errors++;
                    $display("FAIL transition: got cyc=%0d st=%0d row=%b idx=%0d col=%b rout=%b required cyc=%0d st=%0d row=%b idx=%0d col=%b rout=%b",
                             cyc, debug_state, row_drive, scan_idx, col_out, row_out,
                             mon_e.cyc, mon_e.st, mon_e.row, mon_e.idx, mon_e.col, mon_e.rout);
                end
            end
        end
    end

    bit idle_bad;

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("reset_row_drive", 16'(row_drive), 16'h000e);
        chk("reset_scan_idx", 16'(scan_idx), 16'h0000);
        chk("reset_state", 16'(debug_state), 16'h0000);
        chk("reset_col_out", 16'(col_out), 16'h000f);
        chk("reset_row_out", 16'(row_out), 16'h000f);
        last_st = 2'd0;
        exp_q.delete();
        mon_en = 1;

        // Idle sweep: more than one full four-row rotation, no column activity.
        idle_bad = 0;
        for (int i = 0; i < 90; i++) begin
            step(1'b1, 1'b0);
            if (col_out !== 4'b1111) idle_bad = 1;
        end
        chk("idle_col_out_quiet", 16'(idle_bad), 16'h0000);

        // Key at row 2, column 1, no hold.
        key_row = 2; key_col = 1; key_on = 1;
        wait_ph(P_LOCK, -1, 1'b0, "key_r2c1_lock");
        chk("lock_col_out", 16'(col_out), 16'h000d);
        chk("lock_row_out", 16'(row_out), 16'h000b);
        run($urandom_range(5, 30), 1'b0);
        key_on = 0;
        run(30, 1'b0);

        // Key press, then hold kept 50 cycles after release.
        key_row = $urandom_range(0, 3); key_col = $urandom_range(0, 3); key_on = 1;
        wait_ph(P_LOCK, -1, 1'b0, "hold50_lock");
        run(5, 1'b1);
        key_on = 0;
        run(50, 1'b1);
        run(30, 1'b0);

        // Hold with no key while the dwell counter sits at 7.
        wait_ph(P_SCAN, DW - 7, 1'b0, "hold_mid_dwell");
        run(10, 1'b1);
        run(30, 1'b0);

        // Key reaches the synchronizer output on the dwell-expiry cycle.
        wait_ph(P_SCAN, 3, 1'b0, "expiry_race");
        key_row = m_idx; key_col = $urandom_range(0, 3); key_on = 1;
        run(10, 1'b0);
        key_on = 0;
        run(30, 1'b0);

        // Random keys and hold bursts.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                key_on = !key_on;
                key_row = $urandom_range(0, 3);
                key_col = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 29) == 0) cur_h = !cur_h;
            step(1'b1, cur_h);
        end
        key_on = 0;
        cur_h = 0;
        run(60, 1'b0);

        // Reset pulse while locked with hold asserted.
        key_row = $urandom_range(0, 3); key_col = $urandom_range(0, 3); key_on = 1;
        wait_ph(P_LOCK, -1, 1'b0, "reset_lock");
        run(3, 1'b1);
        key_on = 0;
        step(1'b0, 1'b1);
        chk("rst_lock_row_drive", 16'(row_drive), 16'h000e);
        chk("rst_lock_scan_idx", 16'(scan_idx), 16'h0000);
        chk("rst_lock_state", 16'(debug_state), 16'h0000);
        chk("rst_lock_col_out", 16'(col_out), 16'h000f);
        run(40, 1'b0);

        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_transitions: got %0d outstanding required 0", exp_q.size());
        end
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_sched.md
KEYPAD_SCAN_SCHED -- requirements
Module: keypad_scan_sched

Interface
REQ-001 Parameter SETTLE, default 4, cycles to wait after a row change before columns are trusted; legal range 1..255.
REQ-002 Parameter DWELL, default 16, cycles each row is sampled before advancing; legal range 1..255.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 col_raw  input  4  asynchronous keypad column lines, active-low.
REQ-006 hold  input  1  downstream key controller busy (debounce/update/wait in progress); freezes scanning.
REQ-007 row_drive  output  4  keypad row drive, active-low one-hot.
REQ-008 col_out  output  4  synchronized columns to the key controller, active-low; 4'b1111 when not valid.
REQ-009 row_out  output  4  row associated with col_out; equals row_drive in SCAN/LOCK, 4'b1111 otherwise.
REQ-010 scan_idx  output  2  index of the driven row, 0..3.
REQ-011 debug_state  output  2  encoded FSM state.

Function
REQ-012 The block SHALL pass col_raw through a 2-flop synchronizer (col_sync); col_raw to col_sync latency is exactly 2 cycles.
REQ-013 States SHALL be SETTLE=0, SCAN=1, LOCK=2, ADVANCE=3; debug_state SHALL equal the state encoding.
REQ-014 SETTLE: counter runs 0..SETTLE-1; on the cycle the counter equals SETTLE-1 the next state is SCAN with counter cleared; col_out and row_out are forced to 4'b1111.
REQ-015 SCAN: col_out=col_sync, row_out=row_drive; dwell counter runs 0..DWELL-1.
REQ-016 In SCAN, if col_sync!=4'b1111 the next state is LOCK, with priority over dwell expiry and over hold.
REQ-017 In SCAN with col_sync==4'b1111 and hold=1, the dwell counter SHALL freeze and the state SHALL remain SCAN.
REQ-018 In SCAN with col_sync==4'b1111, hold=0 and counter==DWELL-1, the next state is ADVANCE.
REQ-019 LOCK: row_drive is frozen; col_out=col_sync, row_out=row_drive; stay while hold=1 or col_sync!=4'b1111; otherwise the next state is ADVANCE.
REQ-020 ADVANCE (exactly 1 cycle): rotate row_drive 1110->1101->1011->0111->1110, scan_idx increments modulo 4 (3 wraps to 0), counter cleared, next state SETTLE; col_out/row_out = 4'b1111.
REQ-021 row_drive SHALL always be one-hot-low; any other value SHALL be forced to 4'b1110 with scan_idx=0 and state SETTLE on the next cycle.
REQ-022 Counters SHALL be 8 bits and SHALL never wrap; no advance is possible without passing through SETTLE.
REQ-023 Outputs SHALL be registered, except col_out/row_out, which are combinational from state, col_sync and row_drive.

Reset
REQ-024 While rstn=0 at posedge clk: state=SETTLE, counter=0, row_drive=4'b1110, scan_idx=0, sync flops=4'b1111; hence col_out=row_out=4'b1111 and debug_state=0.
REQ-025 Reset asserted mid-SCAN or mid-LOCK SHALL abandon the row immediately, regardless of hold or col_raw.

Structure
REQ-026 Shared package keypad_pkg SHALL hold scan_state_t (2-bit enum), NUM_ROWS=4 and COL_IDLE=4'b1111.
REQ-027 The synchronizer SHALL be a separate sub-module sync2 (parameterized width, reset value all-ones); all other logic SHALL stay in keypad_scan_sched.

Verification
REQ-028 Idle sweep, SETTLE=4, DWELL=16, col_raw=1111, hold=0 -> row_drive changes every 21 cycles; full 1110..0111..1110 cycle = 84 cycles; col_out is never !=1111.
REQ-029 Key row2/col1 (bench drives col_raw=1101 only while row_drive=1011) -> LOCK within 2 cycles of SCAN entry; col_out=1101, row_out=1011; row_drive held until release, then ADVANCE to 0111.
REQ-030 Key press with hold=1 held 50 cycles after release -> LOCK persists for those 50 cycles, then exactly 1 ADVANCE cycle, then SETTLE.
REQ-031 hold=1 with no key in SCAN at counter=7 for 10 cycles -> counter stays 7; after hold drops, expiry occurs 8 cycles later.
REQ-032 Key appears in the same cycle as dwell expiry -> LOCK is taken, not ADVANCE.
REQ-033 rstn=0 for 1 cycle during LOCK with hold=1 -> next cycle row_drive=1110, scan_idx=0, state SETTLE, col_out=1111.
